// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: instruction handshake, register-file controls and data-memory handshake
// bundled between the instruction source/datapath (master) and the sequencer (slave).
`timescale 1ns/1ps
interface regfile_sequencer_if;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  SA;
  logic [2:0]  SB;
  logic [2:0]  DR;
  logic        LD;
  logic [1:0]  D_SEL;
  logic [7:0]  IMM;
  logic [2:0]  ALU_OP;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        MEM_RDY;
  logic        HALTED;
  logic        ILLEGAL;
  logic [7:0]  RETIRED;

  modport master (
    output INSTR, INSTR_VALID, MEM_RDY,
    input  INSTR_READY, SA, SB, DR, LD, D_SEL, IMM, ALU_OP,
           MEM_REQ, MEM_WE, HALTED, ILLEGAL, RETIRED
  );

  modport slave (
    input  INSTR, INSTR_VALID, MEM_RDY,
    output INSTR_READY, SA, SB, DR, LD, D_SEL, IMM, ALU_OP,
           MEM_REQ, MEM_WE, HALTED, ILLEGAL, RETIRED
  );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle control FSM for the 8x8 register-file datapath.
// Define SEQ_TIMEOUT_EN to add the memory-wait abort counter (limit = TIMEOUT cycles).
`timescale 1ns/1ps
module regfile_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  regfile_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] MEMWAIT   = 3'd2;
  localparam logic [2:0] WRITEBACK = 3'd3;
  localparam logic [2:0] HALT_ST   = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_LDM  = 4'd3;
  localparam logic [3:0] OP_STM  = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd5;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("regfile_sequencer: TIMEOUT must be within 1..255");
  end

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [3:0] opcode_r;
  logic [2:0] sa_r;
  logic [2:0] sb_r;
  logic [2:0] dr_r;
  logic [2:0] alu_op_r;
  logic [7:0] imm_r;
  logic [1:0] d_sel_r;
  logic [7:0] retired_r;
  logic       ld_r;
  logic       mem_req_r;
  logic       mem_we_r;
  logic       halted_r;
  logic       illegal_r;
  logic       accept_s;
  logic       retire_s;
  logic       timeout_s;
  logic       abort_s;

  function automatic logic [1:0] dsel_of(input logic [3:0] op);
    case (op)
      OP_LDI:  return 2'd1;
      OP_LDM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign accept_s = (state_r == IDLE) && bus.INSTR_VALID;

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  assign timeout_s = (wait_cnt_r == 8'(TIMEOUT - 1));

  // Counts consecutive MEMWAIT cycles; restarts from zero on every new memory access.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == MEMWAIT) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and retirement decode; a completing MEM_RDY wins over a same-cycle timeout.
  always_comb begin
    state_nxt_s = state_r;
    retire_s    = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.INSTR_VALID) state_nxt_s = DECODE;
        else                 state_nxt_s = IDLE;
      end
      DECODE: begin
        case (opcode_r)
          OP_NOP:         begin state_nxt_s = IDLE;    retire_s = 1'b1; end
          OP_ALU, OP_LDI: state_nxt_s = WRITEBACK;
          OP_LDM, OP_STM: state_nxt_s = MEMWAIT;
          OP_HALT:        begin state_nxt_s = HALT_ST; retire_s = 1'b1; end
          default:        state_nxt_s = IDLE;
        endcase
      end
      MEMWAIT: begin
        if (bus.MEM_RDY) begin
          if (opcode_r == OP_STM) begin
            state_nxt_s = IDLE;
            retire_s    = 1'b1;
          end else begin
            state_nxt_s = WRITEBACK;
          end
        end else if (timeout_s) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = MEMWAIT;
        end
      end
      WRITEBACK: begin
        state_nxt_s = IDLE;
        retire_s    = 1'b1;
      end
      HALT_ST: state_nxt_s = HALT_ST;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched instruction fields and registered control outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      opcode_r  <= 4'd0;
      sa_r      <= 3'd0;
      sb_r      <= 3'd0;
      dr_r      <= 3'd0;
      alu_op_r  <= 3'd0;
      imm_r     <= 8'd0;
      d_sel_r   <= 2'd0;
      retired_r <= 8'd0;
      ld_r      <= 1'b0;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        opcode_r <= bus.INSTR[15:12];
        dr_r     <= bus.INSTR[11:9];
        sa_r     <= bus.INSTR[8:6];
        sb_r     <= bus.INSTR[5:3];
        alu_op_r <= bus.INSTR[2:0];
        imm_r    <= {5'b00000, bus.INSTR[2:0]};
        d_sel_r  <= dsel_of(bus.INSTR[15:12]);
      end
      ld_r      <= (state_nxt_s == WRITEBACK);
      mem_req_r <= (state_nxt_s == MEMWAIT);
      mem_we_r  <= (state_nxt_s == MEMWAIT) && (opcode_r == OP_STM);
      halted_r  <= (state_nxt_s == HALT_ST);
      // Undefined opcodes flag in their DECODE cycle; aborts flag in the first IDLE cycle.
      illegal_r <= (accept_s && (bus.INSTR[15:12] > OP_HALT)) || abort_s;
      if (retire_s) retired_r <= retired_r + 8'd1;
    end
  end

  assign bus.INSTR_READY = (state_r == IDLE);
  assign bus.SA          = sa_r;
  assign bus.SB          = sb_r;
  assign bus.DR          = dr_r;
  assign bus.LD          = ld_r;
  assign bus.D_SEL       = d_sel_r;
  assign bus.IMM         = imm_r;
  assign bus.ALU_OP      = alu_op_r;
  assign bus.MEM_REQ     = mem_req_r;
  assign bus.MEM_WE      = mem_we_r;
  assign bus.HALTED      = halted_r;
  assign bus.ILLEGAL     = illegal_r;
  assign bus.RETIRED     = retired_r;
endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle control sequencer for the 8-bit datapath's 8×8 register file (two read ports SA/SB, one write port DR/LD). Accepts 16-bit instructions over a valid/ready handshake, drives register-file selects, ALU op, write-data source and memory handshake, and retires one instruction at a time. Sits between the instruction source and the register file, ALU and data-memory interface.

## Interface
- `TIMEOUT`, default 15: memory-wait abort limit in cycles; used only with `SEQ_TIMEOUT_EN`, legal range 1–255.
- `CLK` input, 1: clock; all state updates on rising edge.
- `RESET` input, 1: synchronous, active-high reset.
- `INSTR` input, 16: [15:12] opcode, [11:9] DR, [8:6] SA, [5:3] SB, [2:0] f3.
- `INSTR_VALID` input, 1: instruction present.
- `INSTR_READY` output, 1: sequencer can accept an instruction.
- `SA` output, 3: register-file read select A.
- `SB` output, 3: register-file read select B.
- `DR` output, 3: register-file write select.
- `LD` output, 1: register-file write enable.
- `D_SEL` output, 2: write-data source; 0 = ALU, 1 = IMM, 2 = memory.
- `IMM` output, 8: zero-extended immediate, {5'b0, f3}.
- `ALU_OP` output, 3: ALU function, equal to f3.
- `MEM_REQ` output, 1: memory request; address is DATA_A.
- `MEM_WE` output, 1: memory write; write data is DATA_B.
- `MEM_RDY` input, 1: memory completion strobe.
- `HALTED` output, 1: HALT executed.
- `ILLEGAL` output, 1: one-cycle pulse for an undefined opcode or a memory timeout.
- `RETIRED` output, 8: retired-instruction count.

## Operation
- States: IDLE, DECODE, MEMWAIT, WRITEBACK, HALT_ST. Reset enters IDLE.
- IDLE: `INSTR_READY` = 1. When `INSTR_VALID` is high, `INSTR` is latched and the FSM moves to DECODE. `INSTR` is ignored in every other state.
- `SA`, `SB`, `DR`, `ALU_OP`, `IMM` and `D_SEL` are registered from the latched instruction. They hold until the next accept.
- Opcodes:
  - 0 NOP: DECODE → IDLE.
  - 1 ALU: DECODE → WRITEBACK with `D_SEL` = 0.
  - 2 LDI: DECODE → WRITEBACK with `D_SEL` = 1.
  - 3 LDM: DECODE → MEMWAIT (`MEM_REQ` = 1, `MEM_WE` = 0) → WRITEBACK with `D_SEL` = 2.
  - 4 STM: DECODE → MEMWAIT (`MEM_REQ` = 1, `MEM_WE` = 1) → IDLE. No writeback.
  - 5 HALT: DECODE → HALT_ST.
  - 6–15: `ILLEGAL` pulses during the DECODE cycle, then IDLE. Not retired.
- MEMWAIT: `MEM_REQ` (and `MEM_WE` for STM) stay high until the first cycle `MEM_RDY` = 1 is sampled. They drop the next cycle. `MEM_RDY` outside MEMWAIT is ignored.
- WRITEBACK: `LD` = 1 for exactly one cycle, then IDLE. `LD` is 0 in all other states.
- `RETIRED` increments by 1 on leaving DECODE for NOP, on leaving WRITEBACK, on STM completion, and on entering HALT_ST. It wraps 255 → 0.
- HALT_ST: `HALTED` = 1 and `INSTR_READY` = 0. Only `RESET` exits.
- `RESET` in any state, including MEMWAIT: all outputs and state are zeroed on that edge, and IDLE is entered the next cycle. An outstanding memory request is dropped without waiting for `MEM_RDY`.

## Timing
- Reset values: `INSTR_READY` = 1 (combinational from IDLE). All other outputs are 0, including `SA`, `SB`, `DR` and `RETIRED`.
- Accept on edge N means DECODE in cycle N+1.
- ALU/LDI: `LD` high in cycle N+2, `INSTR_READY` high again in cycle N+3. Throughput is 1 instruction per 3 cycles.
- NOP/illegal: `INSTR_READY` high again in cycle N+2.
- LDM: `MEM_REQ` is high from cycle N+2. If `MEM_RDY` is sampled in cycle M, `LD` is high in cycle M+1 and `INSTR_READY` is high in cycle M+2.
- STM: if `MEM_RDY` is sampled in cycle M, `INSTR_READY` is high in cycle M+1.
- `MEM_RDY` in the first MEMWAIT cycle is legal (zero-wait memory).
- `SA`/`SB` are stable from DECODE onward, so the register-file read data is valid for the ALU and memory through WRITEBACK.

## Configuration
- Macro `SEQ_TIMEOUT_EN`.
- Defined: an 8-bit wait counter runs in MEMWAIT. If `MEM_RDY` has not arrived after `TIMEOUT` MEMWAIT cycles, `MEM_REQ`/`MEM_WE` drop, `ILLEGAL` pulses for 1 cycle, the FSM returns to IDLE with no `LD`, and `RETIRED` does not increment.
- Not defined: MEMWAIT waits indefinitely. No counter logic is synthesized.

## Test plan
- Reset then LDI: `INSTR` = 0x2A05 (DR = 5, f3 = 5) accepted at N -> `LD` = 1, `DR` = 5, `D_SEL` = 1, `IMM` = 0x05 in cycle N+2. `RETIRED` = 1 and `INSTR_READY` = 1 at N+3.
- ALU back-to-back: 0x1E53 then 0x1C1A with `INSTR_VALID` held high -> accepts exactly 3 cycles apart. `SA`/`SB` = 1/2 then 0/3, `ALU_OP` = 3 then 2. `RETIRED` = 2.
- LDM with `MEM_RDY` delayed 4 cycles -> `MEM_REQ` high 4 cycles, `MEM_WE` = 0, `LD` one cycle after `MEM_RDY` with `D_SEL` = 2. STM with zero-wait `MEM_RDY` -> `MEM_REQ` and `MEM_WE` high 1 cycle, no `LD`.
- Opcode 0xF -> `ILLEGAL` pulse in the DECODE cycle, no `LD`, `RETIRED` unchanged. HALT 0x5000 -> `HALTED` = 1, `INSTR_READY` = 0 for 20+ cycles; `RESET` restores IDLE and `RETIRED` = 0.
- Wrap and reset: 256 NOPs -> `RETIRED` wraps to 0. `RESET` asserted during LDM MEMWAIT -> `MEM_REQ` = 0 next cycle, no `LD`, IDLE.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT` = 15: LDM with `MEM_RDY` never asserted -> `MEM_REQ` drops after 15 cycles, `ILLEGAL` pulses, no `LD`. Without the macro, `MEM_REQ` stays high indefinitely.
